// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_pkg;

   // Defaults match the original 32 x 32 RISC-V register file.
   localparam int REGFILE_XLEN  = 32;
   localparam int REGFILE_NREGS = 32;
   localparam int REGFILE_AW    = $clog2(REGFILE_NREGS);

   // Register index and data word at the default geometry.
   typedef logic [REGFILE_AW-1:0]   reg_addr_t;
   typedef logic [REGFILE_XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-register scoreboard: one bit per register, set by reservation, cleared by writeback/flush.
// Latency: pending updates at the edge; rsv_ready and blocked are combinational from current state.
// Backpressure: refuses a reservation (rsv_ready=0) on a register already pending and not being written.
//
// Ports: clk/reset_n; wr_addr/wr_data_valid (clear); rsv_addr/rsv_valid/rsv_ready (set);
//        flush (clear all); rd_addr per read port -> blocked per read port; pending vector.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREGS    = REGFILE_NREGS,
   parameter  int ZERO_REG = 1,
   parameter  int NRD      = 2,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [AW-1:0]          wr_addr,
   input  logic                   wr_data_valid,
   input  logic [AW-1:0]          rsv_addr,
   input  logic                   rsv_valid,
   output logic                   rsv_ready,
   input  logic                   flush,
   input  logic [NRD-1:0][AW-1:0] rd_addr,
   output logic [NRD-1:0]         blocked,
   output logic [NREGS-1:0]       pending
);

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;
   logic             zero_rsv;
   logic             rsv_take;

   // A register being written this cycle may be re-reserved: the write
   // clears the bit and the reservation sets it again at the same edge.
   always_comb begin
      zero_rsv  = (ZERO_REG != 0) && (rsv_addr == '0);
      rsv_ready = zero_rsv || !pending_q[rsv_addr] ||
                  (wr_data_valid && (wr_addr == rsv_addr));
      rsv_take  = rsv_valid && rsv_ready && !flush && !zero_rsv;
   end

   // Priority, lowest to highest: hold, write clear, flush, reservation.
   // Flush already suppresses rsv_take, so it effectively wins over it.
   always_comb begin
      pending_d = pending_q;
      if (wr_data_valid) begin
         pending_d[wr_addr] = 1'b0;
      end
      if (flush) begin
         pending_d = '0;
      end
      if (rsv_take) begin
         pending_d[rsv_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         pending_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         blocked[p] = pending_q[rd_addr[p]];
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (NRD read ports, one write port) with a pending-register interlock.
// Latency: 1 cycle for read data/ack and for write ack; same-cycle write forwarded when BYPASS=1.
// Backpressure: a read of a pending register is not acked until writeback; reservations gated by rsv_ready.
//
// Ports: clk, reset_n (async active-low);
//        rd_addr/rd_addr_valid -> rd_data/rd_data_ack (registered, one set per port);
//        wr_addr/wr_data/wr_data_valid -> wr_ack (registered);
//        rsv_addr/rsv_valid/rsv_ready (combinational ready); flush; pending (scoreboard state).
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int XLEN     = REGFILE_XLEN,
   parameter  int NREGS    = REGFILE_NREGS,
   parameter  int NRD      = 2,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NRD-1:0][AW-1:0]   rd_addr,
   input  logic [NRD-1:0]           rd_addr_valid,
   output logic [NRD-1:0][XLEN-1:0] rd_data,
   output logic [NRD-1:0]           rd_data_ack,
   input  logic [AW-1:0]            wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic                     wr_data_valid,
   output logic                     wr_ack,
   input  logic [AW-1:0]            rsv_addr,
   input  logic                     rsv_valid,
   output logic                     rsv_ready,
   input  logic                     flush,
   output logic [NREGS-1:0]         pending
);

   logic [XLEN-1:0] regs [NREGS];
   logic [NRD-1:0]  blocked;
   logic            wr_en;

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG),
      .NRD      (NRD)
   ) u_scoreboard (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_addr       (wr_addr),
      .wr_data_valid (wr_data_valid),
      .rsv_addr      (rsv_addr),
      .rsv_valid     (rsv_valid),
      .rsv_ready     (rsv_ready),
      .flush         (flush),
      .rd_addr       (rd_addr),
      .blocked       (blocked),
      .pending       (pending)
   );

   // Writes to x0 are dropped when it is hardwired, but still acked.
   assign wr_en = wr_data_valid && !((ZERO_REG != 0) && (wr_addr == '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
         wr_ack <= 1'b0;
      end else begin
         if (wr_en) begin
            regs[wr_addr] <= wr_data;
         end
         wr_ack <= wr_data_valid;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic            hit_wr;
      logic            is_zero;
      logic [XLEN-1:0] data_q;
      logic            ack_q;

      assign hit_wr  = wr_data_valid && (wr_addr == rd_addr[i]);
      assign is_zero = (ZERO_REG != 0) && (rd_addr[i] == '0);

      // Forwarding is checked before the pending lookup so a writeback
      // releases a stalled read in the same cycle when BYPASS=1. With
      // BYPASS=0 the stall lasts one more cycle and then reads the array.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            data_q <= '0;
            ack_q  <= 1'b0;
         end else if (!rd_addr_valid[i]) begin
            ack_q <= 1'b0;
         end else if (is_zero) begin
            data_q <= '0;
            ack_q  <= 1'b1;
         end else if ((BYPASS != 0) && hit_wr) begin
            data_q <= wr_data;
            ack_q  <= 1'b1;
         end else if (blocked[i]) begin
            ack_q <= 1'b0;
         end else begin
            data_q <= regs[rd_addr[i]];
            ack_q  <= 1'b1;
         end
      end

      assign rd_data[i]     = data_q;
      assign rd_data_ack[i] = ack_q;
   end

endmodule
